// File: rtl/yadge_pkg.sv
// Shared types and lookup tables for the yadge dice engine.
// YADGE_PIPS_EN selects the pip-LED idle pattern instead of the 7-segment dash.
package yadge_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ROLLING,
    SHOW
  } state_t;

  typedef enum logic [1:0] {
    DIE_D6 = 2'b00,
    DIE_D4 = 2'b01,
    DIE_D8 = 2'b10,
    DIE_D2 = 2'b11
  } die_t;

`ifdef YADGE_PIPS_EN
  localparam logic [7:0] IDLE_PATTERN = 8'h00;
`else
  localparam logic [7:0] IDLE_PATTERN = 8'h40;
`endif

  function automatic logic [3:0] sides(input die_t die);
    case (die)
      DIE_D4:  sides = 4'd4;
      DIE_D8:  sides = 4'd8;
      DIE_D2:  sides = 4'd2;
      default: sides = 4'd6;
    endcase
  endfunction

  // Active-high segments {g,f,e,d,c,b,a}
  function automatic logic [6:0] seg_lut(input logic [3:0] face);
    case (face)
      4'd1:    seg_lut = 7'h06;
      4'd2:    seg_lut = 7'h5B;
      4'd3:    seg_lut = 7'h4F;
      4'd4:    seg_lut = 7'h66;
      4'd5:    seg_lut = 7'h6D;
      4'd6:    seg_lut = 7'h7D;
      4'd7:    seg_lut = 7'h07;
      4'd8:    seg_lut = 7'h7F;
      default: seg_lut = 7'h40;
    endcase
  endfunction

  // Pips {BR,BL,MR,ML,TR,TL,centre}; an eight also lights the top bit
  function automatic logic [7:0] pip_lut(input logic [3:0] face);
    case (face)
      4'd1:    pip_lut = 8'h01;
      4'd2:    pip_lut = 8'h42;
      4'd3:    pip_lut = 8'h43;
      4'd4:    pip_lut = 8'h66;
      4'd5:    pip_lut = 8'h67;
      4'd6:    pip_lut = 8'h7E;
      4'd7:    pip_lut = 8'h7F;
      4'd8:    pip_lut = 8'hFF;
      default: pip_lut = 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/yadge_sync_edge.sv
// Two-flop synchronizer for the roll button with a one-cycle rising-edge pulse.
module yadge_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic pulse
);

  logic s1, s2, prev;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1   <= 1'b0;
      s2   <= 1'b0;
      prev <= 1'b0;
    end else begin
      s1   <= din;
      s2   <= s1;
      prev <= s2;
    end
  end

  assign pulse = s2 & ~prev;

endmodule

// File: rtl/yadge_core.sv
// Dice engine core: a button press tumbles fast-changing faces, then latches a result 1..N.
// Define YADGE_PIPS_EN to drive a pip-LED die on uo_out instead of the 7-segment digit.
module yadge_core
  import yadge_pkg::*;
#(
  parameter int TUMBLE_CYCLES = 4096,
  parameter int STEP_CYCLES   = 256
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ena,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  localparam int TW = $clog2(TUMBLE_CYCLES);
  localparam int SW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam logic [TW-1:0] TUMBLE_LAST = TW'(TUMBLE_CYCLES - 1);
  localparam logic [SW-1:0] STEP_LAST   = SW'(STEP_CYCLES - 1);

  state_t        state, state_n;
  logic [3:0]    cnt, cnt_n;
  logic [3:0]    n_roll, n_roll_n;
  logic [3:0]    face, face_n;
  logic [3:0]    result, result_n;
  logic [3:0]    roll_count, roll_count_n;
  logic [TW-1:0] tumble_cnt, tumble_n;
  logic [SW-1:0] step_cnt, step_n;
  logic [3:0]    n_live;
  logic [3:0]    clamped;
  logic          press;
  logic          rolling;
  logic          unused_pins;

  assign unused_pins = ^{ena, uio_in, ui_in[7:3]};
  assign n_live      = sides(die_t'(ui_in[2:1]));
  assign clamped     = (cnt > n_roll) ? n_roll : cnt;
  assign rolling     = (state == ROLLING);
  assign uio_oe      = 8'hFF;

  yadge_sync_edge u_sync (
    .clk  (clk),
    .rst  (rst),
    .din  (ui_in[0]),
    .pulse(press)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= 4'd1;
      n_roll     <= 4'd6;
      face       <= 4'd1;
      result     <= 4'd1;
      roll_count <= 4'd0;
      tumble_cnt <= '0;
      step_cnt   <= '0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      n_roll     <= n_roll_n;
      face       <= face_n;
      result     <= result_n;
      roll_count <= roll_count_n;
      tumble_cnt <= tumble_n;
      step_cnt   <= step_n;
    end
  end

  // step_cnt tracks tumble_cnt modulo STEP_CYCLES without a divider
  always_comb begin
    state_n      = state;
    cnt_n        = (cnt >= n_live) ? 4'd1 : cnt + 4'd1;
    n_roll_n     = n_roll;
    face_n       = face;
    result_n     = result;
    roll_count_n = roll_count;
    tumble_n     = tumble_cnt;
    step_n       = step_cnt;
    case (state)
      IDLE, SHOW: begin
        if (press) begin
          state_n  = ROLLING;
          n_roll_n = n_live;
          tumble_n = '0;
          step_n   = '0;
          face_n   = cnt;
        end
      end
      ROLLING: begin
        tumble_n = tumble_cnt + TW'(1);
        step_n   = (step_cnt == STEP_LAST) ? '0 : step_cnt + SW'(1);
        if (step_cnt == '0) begin
          face_n = cnt;
        end
        if (tumble_cnt == TUMBLE_LAST) begin
          result_n     = clamped;
          face_n       = clamped;
          roll_count_n = roll_count + 4'd1;
          state_n      = SHOW;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    uo_out  = IDLE_PATTERN;
    uio_out = 8'h00;
    if (state != IDLE) begin
`ifdef YADGE_PIPS_EN
      uo_out = pip_lut(face) | {rolling, 7'b0};
`else
      uo_out = {rolling, seg_lut(face)};
`endif
      uio_out = {roll_count, rolling, 3'(result - 4'd1)};
    end
  end

endmodule

// File: tb/tb_yadge_core.sv
// Self-checking bench for yadge_core: vector table of rolls plus scoreboard of predicted results.
module tb_yadge_core;

  localparam int TUMBLE = 16;
  localparam int STEP   = 4;
  localparam int NVEC   = 20;

  logic       clk = 1'b0;
  logic       rst;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  yadge_core #(
    .TUMBLE_CYCLES(TUMBLE),
    .STEP_CYCLES  (STEP)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .ena    (ena),
    .ui_in  (ui_in),
    .uo_out (uo_out),
    .uio_in (uio_in),
    .uio_out(uio_out),
    .uio_oe (uio_oe)
  );

  always #5 clk = ~clk;

  typedef struct {
    int value;
    int max_n;
  } expect_t;

  typedef struct {
    logic [1:0] die;
    int         n_sides;
    int         offset;
  } roll_vec_t;

  expect_t    exp_q[$];
  roll_vec_t  vecs[NVEC];
  logic [1:0] die_list[4] = '{2'b00, 2'b01, 2'b10, 2'b11};
  int         n_list[4]   = '{6, 4, 8, 2};
  logic [7:0] face_pat[9];
  logic [7:0] idle_exp;

  int   n_cmp = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   m_cnt = 1;
  int   done_rolls = 0;
  int   exp_count = 0;
  int   last_result = 0;
  int   run_len = 0;
  int   rolls = 0;
  int   mask = 0;
  logic prev_rolling = 1'b0;
  int   mon_r;
  expect_t mon_e;

  function automatic int sidesOf(input logic [1:0] d);
    case (d)
      2'b00:   return 6;
      2'b01:   return 4;
      2'b10:   return 8;
      default: return 2;
    endcase
  endfunction

  // Result is the counter value sampled TUMBLE+2 edges after the press edge
  function automatic int predictResult(input int c, input int n);
    int v = c;
    for (int i = 0; i < TUMBLE + 2; i++) v = (v >= n) ? 1 : v + 1;
    return (v > n) ? n : v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_cmp++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input int hold, input bit predict);
    expect_t e;
    @(negedge clk);
    if (predict) begin
      e.value = predictResult(m_cnt, sidesOf(ui_in[2:1]));
      e.max_n = sidesOf(ui_in[2:1]);
      exp_q.push_back(e);
    end
    ui_in[0] = 1'b1;
    repeat (hold) @(negedge clk);
    ui_in[0] = 1'b0;
  endtask

  task automatic waitRolls(input int target);
    int t = 0;
    while (done_rolls < target && t < 300) begin
      @(negedge clk);
      t++;
    end
    checkOutput("roll_completed", done_rolls, target);
  endtask

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst) m_cnt <= 1;
    else     m_cnt <= (m_cnt >= sidesOf(ui_in[2:1])) ? 1 : m_cnt + 1;
  end

  // Monitor: a falling rolling flag marks a finished roll; pop and compare its prediction
  always @(negedge clk) begin
    if (rst) begin
      run_len      = 0;
      prev_rolling = 1'b0;
      exp_count    = 0;
    end else begin
      if (uio_out[3]) begin
        run_len++;
      end else if (prev_rolling) begin
        checkOutput("roll_length", run_len, TUMBLE);
        mon_r = int'(uio_out[2:0]) + 1;
        checkOutput("scoreboard_pending", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          mon_e = exp_q.pop_front();
          if (mon_e.value != 0) checkOutput("result", mon_r, mon_e.value);
          checkOutput("result_range", (mon_r >= 1 && mon_r <= mon_e.max_n), 1);
        end
        checkOutput("show_display", uo_out, face_pat[mon_r]);
        exp_count = (exp_count + 1) % 16;
        checkOutput("roll_count", uio_out[7:4], exp_count);
        last_result = mon_r;
        done_rolls++;
        run_len = 0;
      end
      prev_rolling = uio_out[3];
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
`ifdef YADGE_PIPS_EN
    face_pat = '{8'h00, 8'h01, 8'h42, 8'h43, 8'h66, 8'h67, 8'h7E, 8'h7F, 8'hFF};
    idle_exp = 8'h00;
`else
    face_pat = '{8'h00, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07, 8'h7F};
    idle_exp = 8'h40;
`endif
    begin
      int k = 0;
      for (int g = 0; g < 4; g++) begin
        for (int o = 0; o < n_list[g]; o++) begin
          vecs[k] = '{die_list[g], n_list[g], o};
          k++;
        end
      end
    end

    rst = 1'b1; ena = 1'b1; ui_in = 8'h00; uio_in = 8'h00;
    repeat (2) @(negedge clk);
    checkOutput("reset_uo_out", uo_out, idle_exp);
    checkOutput("reset_uio_out", uio_out, 8'h00);
    checkOutput("reset_uio_oe", uio_oe, 8'hFF);
    rst = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      checkOutput("idle_hold", {uo_out, uio_out}, {idle_exp, 8'h00});
    end

    // First roll on a d6: rolling must appear exactly on the third edge
    begin
      expect_t e;
      @(negedge clk);
      e.value = predictResult(m_cnt, 6);
      e.max_n = 6;
      exp_q.push_back(e);
      ui_in[0] = 1'b1;
      @(negedge clk);
      ui_in[0] = 1'b0;
      checkOutput("rolling_edge1", uio_out[3], 1'b0);
      @(negedge clk);
      checkOutput("rolling_edge2", uio_out[3], 1'b0);
      @(negedge clk);
      checkOutput("rolling_edge3", uio_out[3], 1'b1);
      checkOutput("dp_edge3", uo_out[7], 1'b1);
      rolls++;
      waitRolls(rolls);
    end

    for (int v = 0; v < NVEC; v++) begin
      if (ui_in[2:1] != vecs[v].die) begin
        ui_in[2:1] = vecs[v].die;
        mask = 0;
        repeat (4) @(negedge clk);
      end
      while (cyc % vecs[v].n_sides != vecs[v].offset) @(negedge clk);
      applyStimulus(1, 1'b1);
      rolls++;
      waitRolls(rolls);
      mask = mask | (1 << last_result);
      if (v == NVEC - 1 || vecs[v+1].die != vecs[v].die)
        checkOutput("distinct_faces", mask, ((1 << vecs[v].n_sides) - 1) << 1);
    end

    // Presses during a roll and a long hold must still give exactly one roll
    ui_in[2:1] = 2'b00;
    repeat (3) @(negedge clk);
    applyStimulus(1, 1'b1);
    repeat (8) @(negedge clk);
    applyStimulus(50, 1'b0);
    repeat (30) @(negedge clk);
    rolls++;
    checkOutput("held_button_rolls", done_rolls, rolls);
    checkOutput("held_button_idle", uio_out[3], 1'b0);

    rst = 1'b1;
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    checkOutput("reset_count", uio_out, 8'h00);
    for (int i = 0; i < 17; i++) begin
      applyStimulus(1, 1'b1);
      rolls++;
      waitRolls(rolls);
    end
    checkOutput("count_wrap", uio_out[7:4], 4'd1);

    applyStimulus(1, 1'b1);
    repeat (6) @(negedge clk);
    rst = 1'b1;
    exp_q.delete();
    @(negedge clk);
    checkOutput("midroll_reset_uo", uo_out, idle_exp);
    checkOutput("midroll_reset_uio", uio_out, 8'h00);
    @(negedge clk);
    rst = 1'b0;

    // Die switch mid-roll keeps the latched d8 range
    ui_in[2:1] = 2'b10;
    repeat (3) @(negedge clk);
    begin
      expect_t e;
      e.value = 0;
      e.max_n = 8;
      exp_q.push_back(e);
    end
    applyStimulus(1, 1'b0);
    repeat (5) @(negedge clk);
    ui_in[2:1] = 2'b11;
    rolls++;
    waitRolls(rolls);
    checkOutput("scoreboard_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
